// File: rtl/lfsr_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_check_pkg
//  Description : Shared types and constants for the LFSR pattern path.
//                - state_t: checker state encoding (SEARCH, VERIFY, LOCKED).
//                - Default 22-bit LFSR length and tap positions (0-indexed).
//                - xnor_tap(): feedback function shared by generator/checker.
//  Revision    : 1.0  initial release
// ============================================================================
package lfsr_check_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int LFSR_LEN    = 22;
    localparam int LFSR_TAP_HI = 21;
    localparam int LFSR_TAP_LO = 20;

    // XNOR feedback: the all-zero state is legal and the all-ones state is
    // the lock-up state.
    function automatic logic xnor_tap(input logic i_Hi, input logic i_Lo);
        return ~(i_Hi ^ i_Lo);
    endfunction

endpackage : lfsr_check_pkg
`default_nettype wire

// File: rtl/lfsr_22_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_22_checker_if
//  Description : Bit-stream and status bundle between a pattern source and
//                the LFSR checker.
//  Signals     : i_Valid      source -> checker  bit qualifier
//                i_Bit        source -> checker  received stream bit
//                o_Locked     checker -> sink    checker is locked
//                o_Error      checker -> sink    one-cycle mismatch pulse
//                o_Seed_Seen  checker -> sink    one-cycle all-zero pulse
//                o_Err_Count  checker -> sink    saturating error count
//  Modports    : master (pattern source / observer), slave (checker)
//  Revision    : 1.0  initial release
// ============================================================================
interface lfsr_22_checker_if #(
    parameter int ERR_WIDTH = 16
);
    logic                 i_Valid;
    logic                 i_Bit;
    logic                 o_Locked;
    logic                 o_Error;
    logic                 o_Seed_Seen;
    logic [ERR_WIDTH-1:0] o_Err_Count;

    modport master (
        output i_Valid,
        output i_Bit,
        input  o_Locked,
        input  o_Error,
        input  o_Seed_Seen,
        input  o_Err_Count
    );

    modport slave (
        input  i_Valid,
        input  i_Bit,
        output o_Locked,
        output o_Error,
        output o_Seed_Seen,
        output o_Err_Count
    );

endinterface : lfsr_22_checker_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all ones instead of wrapping.
//                Clear has priority over increment.
//  Parameters  : WIDTH    counter width in bits
//  Ports       : i_Clk    clock
//                i_Rst_L  synchronous active-low reset
//                i_Clear  synchronous clear
//                i_Inc    increment request
//                o_Count  current count (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Clear,
    input  logic             i_Inc,
    output logic [WIDTH-1:0] o_Count
);

    logic [WIDTH-1:0] r_Count;
    logic             w_Full;

    assign w_Full = &r_Count;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || i_Clear) begin
            r_Count <= '0;
        end else if (i_Inc && !w_Full) begin
            r_Count <= r_Count + WIDTH'(1);
        end
    end

    assign o_Count = r_Count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/lfsr_22_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_22_checker
//  Description : Self-synchronising receiver/checker for the XNOR LFSR
//                stream of lfsr_22 (taps NUM_BITS-1 and NUM_BITS-2).
//                SEARCH fills the window, VERIFY counts consecutive correct
//                predictions until LOCK_COUNT, LOCKED free-runs the window on
//                its own prediction (flywheel) and flags mismatching bits.
//  Parameters  : NUM_BITS    LFSR length
//                LOCK_COUNT  consecutive matches to lock (1..255)
//                LOSS_COUNT  consecutive misses to drop lock (1..15)
//                ERR_WIDTH   error counter width
//  Ports       : i_Clk       clock
//                i_Rst_L     synchronous active-low reset
//                bus         lfsr_22_checker_if.slave
//                            (i_Valid, i_Bit in; o_Locked, o_Error,
//                             o_Seed_Seen, o_Err_Count out, all registered)
//  Build macro : LFSR_CHECK_ERR_COUNT_EN  defined   -> saturating error count
//                                         undefined -> o_Err_Count tied to 0
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_22_checker
    import lfsr_check_pkg::*;
#(
    parameter int NUM_BITS   = LFSR_LEN,
    parameter int LOCK_COUNT = 32,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    lfsr_22_checker_if.slave    bus
);

    localparam int                  c_FILL_W    = $clog2(NUM_BITS + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_DONE = c_FILL_W'(NUM_BITS);
    localparam logic [7:0]          c_LOCK      = 8'(LOCK_COUNT);
    localparam logic [3:0]          c_LOSS      = 4'(LOSS_COUNT);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                r_State;
    logic [NUM_BITS-1:0]   r_Win;
    logic [c_FILL_W-1:0]   r_Fill;
    logic [7:0]            r_Match;
    logic [3:0]            r_Miss;
    logic                  r_Locked;
    logic                  r_Error;
    logic                  r_Seed;

    state_t                w_StateNxt;
    logic [NUM_BITS-1:0]   w_WinNxt;
    logic [c_FILL_W-1:0]   w_FillNxt;
    logic [7:0]            w_MatchNxt;
    logic [3:0]            w_MissNxt;
    logic                  w_ErrNxt;
    logic                  w_SeedNxt;
    logic                  w_Pred;
    logic                  w_WinOnes;
    logic [ERR_WIDTH-1:0]  w_ErrCount;

    assign w_Pred    = xnor_tap(r_Win[NUM_BITS-1], r_Win[NUM_BITS-2]);
    assign w_WinOnes = &r_Win;

    // ------------------------------------------------------------------------
    // Next-state / next-datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_StateNxt = r_State;
        w_WinNxt   = r_Win;
        w_FillNxt  = r_Fill;
        w_MatchNxt = r_Match;
        w_MissNxt  = r_Miss;
        w_ErrNxt   = 1'b0;
        w_SeedNxt  = 1'b0;

        if (bus.i_Valid) begin
            unique case (r_State)
                SEARCH: begin
                    w_WinNxt  = {r_Win[NUM_BITS-2:0], bus.i_Bit};
                    w_FillNxt = r_Fill + c_FILL_W'(1);
                    if (w_FillNxt == c_FILL_DONE) begin
                        w_StateNxt = VERIFY;
                        w_MatchNxt = '0;
                    end
                end

                VERIFY: begin
                    w_WinNxt = {r_Win[NUM_BITS-2:0], bus.i_Bit};
                    // An all-ones window is the XNOR lock-up state: it
                    // predicts 1 forever, so a stuck-high line would
                    // otherwise lock. Treat every bit there as a miss.
                    if (!w_WinOnes && (bus.i_Bit == w_Pred)) begin
                        w_MatchNxt = r_Match + 8'd1;
                        if (w_MatchNxt == c_LOCK) begin
                            w_StateNxt = LOCKED;
                        end
                    end else begin
                        w_MatchNxt = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel: shift in the prediction, not the received
                    // bit, so an isolated bad bit cannot poison later
                    // predictions.
                    w_WinNxt = {r_Win[NUM_BITS-2:0], w_Pred};
                    if (bus.i_Bit != w_Pred) begin
                        w_ErrNxt  = 1'b1;
                        w_MissNxt = r_Miss + 4'd1;
                        if (w_MissNxt == c_LOSS) begin
                            w_StateNxt = SEARCH;
                            w_FillNxt  = '0;
                            w_MatchNxt = '0;
                            w_MissNxt  = '0;
                        end
                    end else begin
                        w_MissNxt = '0;
                    end
                end

                default: begin
                    w_StateNxt = SEARCH;
                    w_FillNxt  = '0;
                    w_MatchNxt = '0;
                    w_MissNxt  = '0;
                end
            endcase

            // Period marker only counts while lock is held through the step.
            w_SeedNxt = (r_State == LOCKED) && (w_StateNxt == LOCKED) &&
                        (w_WinNxt == '0);
        end
    end

    // ------------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State  <= SEARCH;
            r_Win    <= '0;
            r_Fill   <= '0;
            r_Match  <= '0;
            r_Miss   <= '0;
            r_Locked <= 1'b0;
            r_Error  <= 1'b0;
            r_Seed   <= 1'b0;
        end else begin
            r_State  <= w_StateNxt;
            r_Win    <= w_WinNxt;
            r_Fill   <= w_FillNxt;
            r_Match  <= w_MatchNxt;
            r_Miss   <= w_MissNxt;
            r_Locked <= (w_StateNxt == LOCKED);
            r_Error  <= w_ErrNxt;
            r_Seed   <= w_SeedNxt;
        end
    end

    // ------------------------------------------------------------------------
    // Error counter: only reset clears it, so it accumulates across relocks.
    // ------------------------------------------------------------------------
`ifdef LFSR_CHECK_ERR_COUNT_EN
    sat_counter #(
        .WIDTH   (ERR_WIDTH)
    ) u_err_cnt (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clear (1'b0),
        .i_Inc   (w_ErrNxt),
        .o_Count (w_ErrCount)
    );
`else
    assign w_ErrCount = '0;
`endif

    assign bus.o_Locked    = r_Locked;
    assign bus.o_Error     = r_Error;
    assign bus.o_Seed_Seen = r_Seed;
    assign bus.o_Err_Count = w_ErrCount;

endmodule : lfsr_22_checker
`default_nettype wire

// File: tb/tb_lfsr_22_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_22_checker
//  Description : Scoreboard bench for lfsr_22_checker. dut22 uses the
//                default 22-bit configuration; dut7 is a 7-bit instance
//                (taps 6/5, period 127) with a 4-bit error counter so the
//                full-period marker and counter saturation fit in a short run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_22_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_22_checker_if #(.ERR_WIDTH(16)) if22 ();
    lfsr_22_checker_if #(.ERR_WIDTH(4))  if7  ();

    lfsr_22_checker #(
        .NUM_BITS   (22),
        .LOCK_COUNT (32),
        .LOSS_COUNT (4),
        .ERR_WIDTH  (16)
    ) dut22 (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (if22)
    );

    lfsr_22_checker #(
        .NUM_BITS   (7),
        .LOCK_COUNT (32),
        .LOSS_COUNT (4),
        .ERR_WIDTH  (4)
    ) dut7 (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (if7)
    );

`ifdef LFSR_CHECK_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        chk;
        logic        lk;
        logic        er;
        logic        sd;
        logic [15:0] cnt;
    } exp_t;

    localparam exp_t NOCHK = '0;

    exp_t        q22[$];
    exp_t        q7[$];
    exp_t        m22;
    exp_t        m7;
    int          total = 0;
    int          bad   = 0;
    logic [21:0] g22;
    logic [6:0]  g7;
    int          n22;
    int          n7;
    int          k7;

    function automatic exp_t mk(input logic lk, input logic er, input logic sd,
                                input logic [15:0] cnt);
        exp_t e;
        e.chk = 1'b1;
        e.lk  = lk;
        e.er  = er;
        e.sd  = sd;
        e.cnt = cnt;
        return e;
    endfunction

    // Expected error count after n errors with a counter that tops out at maxv.
    function automatic logic [15:0] ecv(input int n, input int maxv);
        int v;
        v = (n > maxv) ? maxv : n;
        return CNT_EN ? v[15:0] : 16'd0;
    endfunction

    task automatic cmpv(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock per DUT, checked mid-cycle.
    always @(negedge clk) begin
        if (q22.size() > 0) begin
            m22 = q22.pop_front();
            if (m22.chk) begin
                cmpv("dut22 locked",    {15'd0, if22.o_Locked},    {15'd0, m22.lk});
                cmpv("dut22 error",     {15'd0, if22.o_Error},     {15'd0, m22.er});
                cmpv("dut22 seed_seen", {15'd0, if22.o_Seed_Seen}, {15'd0, m22.sd});
                cmpv("dut22 err_count", if22.o_Err_Count,          m22.cnt);
            end
        end
        if (q7.size() > 0) begin
            m7 = q7.pop_front();
            if (m7.chk) begin
                cmpv("dut7 locked",     {15'd0, if7.o_Locked},     {15'd0, m7.lk});
                cmpv("dut7 error",      {15'd0, if7.o_Error},      {15'd0, m7.er});
                cmpv("dut7 seed_seen",  {15'd0, if7.o_Seed_Seen},  {15'd0, m7.sd});
                cmpv("dut7 err_count",  {12'd0, if7.o_Err_Count},  m7.cnt);
            end
        end
    end

    // One clock of stimulus for both DUTs plus the expected result of that edge.
    task automatic step(input logic r,
                        input logic v22, input logic b22, input exp_t e22,
                        input logic v7,  input logic b7,  input exp_t e7);
        rst_n        = r;
        if22.i_Valid = v22;
        if22.i_Bit   = b22;
        if7.i_Valid  = v7;
        if7.i_Bit    = b7;
        q22.push_back(e22);
        q7.push_back(e7);
        @(posedge clk);
        #1;
    endtask

    // Next lfsr_22 bit into dut22, optionally inverted on the wire.
    task automatic f22(input logic flip, input logic lk, input logic er);
        logic b;
        b   = ~(g22[21] ^ g22[20]);
        g22 = {g22[20:0], b};
        if (er) n22++;
        step(1'b1, 1'b1, b ^ flip, mk(lk, er, 1'b0, ecv(n22, 65535)),
             1'b0, 1'b0, NOCHK);
    endtask

    // Next 7-bit LFSR bit into dut7; its window is back at zero every 127 steps.
    task automatic f7(input logic flip, input logic lk, input logic er);
        logic b;
        b  = ~(g7[6] ^ g7[5]);
        g7 = {g7[5:0], b};
        k7++;
        if (er) n7++;
        step(1'b1, 1'b0, 1'b0, NOCHK,
             1'b1, b ^ flip, mk(lk, er, lk && ((k7 % 127) == 0), ecv(n7, 15)));
    endtask

    initial begin
        if22.i_Valid = 1'b0;
        if22.i_Bit   = 1'b0;
        if7.i_Valid  = 1'b0;
        if7.i_Bit    = 1'b0;
        g22 = '0;
        g7  = '0;
        n22 = 0;
        n7  = 0;
        k7  = 0;

        // Reset state
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0),
                 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0));

        // Clean stream: lock exactly at the 54th valid bit
        for (int k = 1; k <= 74; k++) f22(1'b0, k >= 54, 1'b0);

        // Single inverted bit: one error, lock held, flywheel keeps it clean
        f22(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 100; k++) f22(1'b0, 1'b1, 1'b0);

        // Four consecutive inverted bits: lock drops with the fourth error
        for (int i = 0; i < 4; i++) f22(1'b1, i < 3, 1'b1);
        // Relock after a full 54-bit acquisition
        for (int k = 1; k <= 60; k++) f22(1'b0, k >= 54, 1'b0);

        // Reset mid-lock with a simultaneous valid bit
        step(1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 16'd0),
             1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0));
        n22 = 0;

        // Stuck-high input never locks
        for (int i = 0; i < 1000; i++)
            step(1'b1, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, ecv(n22, 65535)),
                 1'b0, 1'b0, NOCHK);

        // dut7: lock at 7+32=39, one seed pulse at step 127, valid gap before it
        for (int k = 1; k <= 170; k++) begin
            if (k == 127) begin
                for (int i = 0; i < 10; i++)
                    step(1'b1, 1'b0, 1'b0, NOCHK,
                         1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, ecv(n7, 15)));
            end
            f7(1'b0, k >= 39, 1'b0);
        end

        // Saturation: 17 isolated errors on a 4-bit counter stop at 15
        for (int i = 0; i < 17; i++) begin
            f7(1'b1, 1'b1, 1'b1);
            f7(1'b0, 1'b1, 1'b0);
        end

        // Reset while locked: everything reads zero on the next cycle
        step(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0),
             1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 16'd0));
        n7 = 0;
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0),
                 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 16'd0));

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lfsr_22_checker
`default_nettype wire

// File: doc/lfsr_22_checker.md
# lfsr_22_checker

Serial receiver and checker for the 22-bit XNOR LFSR stream produced by `lfsr_22`: one bit is consumed per valid cycle. The block self-synchronises to the stream, declares lock after a run of correct predictions and flags each mismatching bit. While locked it counts errors and pulses a marker each time the sequence passes the all-zero seed. It sits on the board top between a pattern source (loopback or external pin) and the LEDs, and is the receiving end of the LFSR pattern path.

## Interface
Parameters:
- `NUM_BITS`, 22: LFSR length. Taps are fixed at bits NUM_BITS-1 and NUM_BITS-2 (0-indexed).
- `LOCK_COUNT`, 32: consecutive correct predictions needed to declare lock (1..255).
- `LOSS_COUNT`, 4: consecutive mispredictions while locked that drop lock (1..15).
- `ERR_WIDTH`, 16: width of the error counter.

Ports:
- `i_Clk`  in  1  single clock.
- `i_Rst_L`  in  1  reset, synchronous, active-low.
- `i_Valid`  in  1  `i_Bit` is valid this cycle.
- `i_Bit`  in  1  received stream bit; this is the new LSB shifted into the generator on that step.
- `o_Locked`  out  1  checker is in LOCKED.
- `o_Error`  out  1  one-cycle pulse; a valid bit mismatched while locked.
- `o_Seed_Seen`  out  1  one-cycle pulse; the locked window has returned to all zeros.
- `o_Err_Count`  out  ERR_WIDTH  saturating count of errors while locked.

## Operation
- Window register `r_Win[NUM_BITS-1:0]`. Predicted bit: `pred = r_Win[NUM_BITS-1] XNOR r_Win[NUM_BITS-2]`. The window updates only on `i_Valid`, as `{r_Win[NUM_BITS-2:0], new}`.
- **SEARCH**
  - `new = i_Bit`. The fill counter increments on each valid bit.
  - When the NUM_BITS-th bit is absorbed, go to VERIFY with match count 0.
- **VERIFY**
  - `new = i_Bit`.
  - If `i_Bit == pred`, the match count increments. Otherwise the match count resets to 0 and the state stays VERIFY.
  - When the match count reaches LOCK_COUNT, go to LOCKED.
  - Lock-up guard: if `r_Win` is all ones, the bit is never a match and the match count resets to 0. A stuck-high input therefore cannot lock.
- **LOCKED**
  - Flywheel: `new = pred`. The received bit is compared but is not shifted in, so one bad bit does not corrupt later predictions.
  - Mismatch: pulse `o_Error`, increment `o_Err_Count` (saturating at all ones, never wraps) and increment the miss count.
  - Match: clear the miss count.
  - When the miss count reaches LOSS_COUNT, go to SEARCH and clear the fill, match and miss counts. The error that triggers the transition is still pulsed and counted.
- `o_Seed_Seen` pulses when the updated window equals 0 while the state is LOCKED and remains LOCKED. It marks one full period of 2^22-1 steps.
- `i_Valid` low: no state, counter or window change, and no pulses.
- `o_Err_Count` is cleared only by reset. It holds its value across lock loss and relock.

## Timing
- All outputs are registered. Reset values: `o_Locked`=0, `o_Error`=0, `o_Seed_Seen`=0, `o_Err_Count`=0, state SEARCH, window and all counters 0.
- Reset is applied at the clock edge when `i_Rst_L`=0, including mid-lock. It overrides any simultaneous valid bit.
- `o_Error` and `o_Seed_Seen` are high in the cycle after the clock edge that samples the offending or seed-completing valid bit.
- `o_Locked` rises the cycle after the LOCK_COUNT-th matching bit is sampled. It falls the cycle after the LOSS_COUNT-th consecutive miss is sampled; that miss's `o_Error` pulse is high in the same cycle.
- Minimum time from reset release to lock: NUM_BITS + LOCK_COUNT valid bits.
- The block accepts back-to-back valid bits at full rate (one per clock).

## Configuration
- `LFSR_CHECK_ERR_COUNT_EN`
  - Defined: the saturating error counter is built as described above.
  - Undefined: the counter logic is omitted and `o_Err_Count` is tied to 0. `o_Error` and all lock behaviour are unchanged.

## Structure
- Shared package `lfsr_check_pkg`:
  - state enum (`SEARCH`, `VERIFY`, `LOCKED`), 2 bits;
  - default constants `LFSR_LEN`=22, `LFSR_TAP_HI`=21, `LFSR_TAP_LO`=20.
- Sub-module `sat_counter`:
  - parameterised width;
  - inputs clear and increment; output the count;
  - saturates at all ones;
  - used for `o_Err_Count` and reusable elsewhere.

## Test plan
- Reset, then feed `lfsr_22` output continuously: `o_Locked` rises exactly 22+32=54 valid bits after reset release; `o_Error` stays 0.
- Locked, invert one bit: a single `o_Error` pulse and `o_Err_Count`=1; lock is held; the next 100 bits produce no further errors (flywheel).
- Locked, invert 4 consecutive bits: 4 error pulses, `o_Locked` falls with the 4th, `o_Err_Count`=4; with a clean stream the block relocks after 54 more bits.
- Hold `i_Bit`=1 with `i_Valid`=1 for 1000 cycles: `o_Locked` never rises.
- Locked, run 2^22-1 valid bits: exactly one `o_Seed_Seen` pulse; drop `i_Valid` for 10 cycles mid-run: no state change and no pulses.
- Force `o_Err_Count` to 0xFFFE, inject 3 errors: the count reads 0xFFFF. Then assert `i_Rst_L`=0 for one edge while locked: all outputs read 0 the next cycle.
